// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: picks one of ALU/MEM writeback each cycle, round-robin with same-rd override.
// Latency: 1 cycle from accepted request to wr_en/wr_addr/wr_data.
// Backpressure: ready is combinational; a requester holds valid/rd/data until its ready is high.
module rf_wr_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            wr_en,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data
);

    logic prio;
    logic same_rd;
    logic alu_wr;
    logic mem_wr;

    // A load to the same nonzero rd is older and must land first, else its stale value would win.
    assign same_rd = (alu_rd == mem_rd) && (alu_rd != 5'd0);

    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst_n && en) begin
            if (alu_valid && mem_valid) begin
                if (same_rd || prio) begin
                    mem_ready = 1'b1;
                end else begin
                    alu_ready = 1'b1;
                end
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
    end

    assign alu_wr = alu_ready && (alu_rd != 5'd0);
    assign mem_wr = mem_ready && (mem_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= '0;
        end else begin
            if (alu_ready) begin
                prio <= 1'b1;
            end else if (mem_ready) begin
                prio <= 1'b0;
            end
            wr_en <= alu_wr || mem_wr;
            if (alu_wr) begin
                wr_addr <= alu_rd;
                wr_data <= alu_data;
            end else if (mem_wr) begin
                wr_addr <= mem_rd;
                wr_data <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter: reset, single write, round-robin, same-rd, x0, enable, mid-op reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requesters active: everything quiet before any clock edge.
        rst_n = 1'b0; en = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_1111;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2222_2222;
        #3;
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
        chk("rst_wr_addr",   {27'd0, wr_addr},   32'd0);
        chk("rst_wr_data",   wr_data,            32'd0);

        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_wr_en", {31'd0, wr_en}, 32'd0);

        // Single ALU write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("single_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("single_wr_en",   {31'd0, wr_en},   32'd1);
        chk("single_wr_addr", {27'd0, wr_addr}, 32'd5);
        chk("single_wr_data", wr_data,          32'hDEAD_BEEF);
        tick();
        chk("single_wr_en_off", {31'd0, wr_en},   32'd0);
        chk("single_addr_hold", {27'd0, wr_addr}, 32'd5);
        chk("single_data_hold", wr_data,          32'hDEAD_BEEF);

        // Fresh reset so prio starts at 0, then contested round-robin.
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA1A1_A1A1;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hB2B2_B2B2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_mem_ready", {31'd0, mem_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr_wr_en",   {31'd0, wr_en},   32'd1);
            chk("rr_wr_addr", {27'd0, wr_addr}, (i % 2 == 0) ? 32'd3 : 32'd7);
            chk("rr_wr_data", wr_data, (i % 2 == 0) ? 32'hA1A1_A1A1 : 32'hB2B2_B2B2);
        end

        // Same rd with prio=0: MEM must still go first.
        alu_rd = 5'd9; alu_data = 32'h0000_AAAA;
        mem_rd = 5'd9; mem_data = 32'h0000_BBBB;
        #1;
        chk("same_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("same_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        mem_valid = 1'b0;
        chk("same_wr1_addr", {27'd0, wr_addr}, 32'd9);
        chk("same_wr1_data", wr_data,          32'h0000_BBBB);
        #1;
        chk("same_alu_next", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("same_wr2_en",   {31'd0, wr_en},   32'd1);
        chk("same_wr2_addr", {27'd0, wr_addr}, 32'd9);
        chk("same_wr2_data", wr_data,          32'h0000_AAAA);

        // x0 write is accepted but suppressed; prio becomes 1.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555_5555;
        #1;
        chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("x0_wr_en",   {31'd0, wr_en},   32'd0);
        chk("x0_addr_hold", {27'd0, wr_addr}, 32'd9);

        // Enable low blocks both and leaves prio=1.
        en = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0001;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h0000_0002;
        #1;
        chk("en0_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("en0_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        chk("en0_wr_en", {31'd0, wr_en}, 32'd0);
        en = 1'b1;
        #1;
        chk("en1_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("en1_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        mem_valid = 1'b0;
        chk("en1_wr_addr", {27'd0, wr_addr}, 32'd2);

        // Grant ALU to rd 4, then reset mid-cycle while the request is still pending.
        alu_rd = 5'd4; alu_data = 32'hCAFE_F00D;
        #1;
        chk("mid_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        chk("mid_wr_en",   {31'd0, wr_en},   32'd1);
        chk("mid_wr_addr", {27'd0, wr_addr}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",   {31'd0, wr_en},     32'd0);
        chk("mid_rst_wr_addr", {27'd0, wr_addr},   32'd0);
        chk("mid_rst_ready",   {31'd0, alu_ready}, 32'd0);
        alu_valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
        end

        // First contested grant after reset goes to ALU.
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_000A;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h0000_000B;
        #1;
        chk("first_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("first_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("first_wr_addr", {27'd0, wr_addr}, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the write-data width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port en, input, 1, global enable; low blocks all new grants.
REQ-005 SHALL have port alu_valid, input, 1, ALU writeback request.
REQ-006 SHALL have port alu_rd, input, 5, ALU destination register.
REQ-007 SHALL have port alu_data, input, XLEN, ALU result.
REQ-008 SHALL have port alu_ready, output, 1, ALU request accepted this cycle.
REQ-009 SHALL have port mem_valid, input, 1, load writeback request.
REQ-010 SHALL have port mem_rd, input, 5, load destination register.
REQ-011 SHALL have port mem_data, input, XLEN, load result.
REQ-012 SHALL have port mem_ready, output, 1, load request accepted this cycle.
REQ-013 SHALL have port wr_en, output, 1, register-file write enable; drives the 5-to-32 write decoder enable.
REQ-014 SHALL have port wr_addr, output, 5, register-file write address; drives the decoder select.
REQ-015 SHALL have port wr_data, output, XLEN, register-file write data.

Function
REQ-016 SHALL grant at most one requester per cycle; a transfer is valid && ready on the same rising edge.
REQ-017 SHALL drive alu_ready and mem_ready combinationally from en, the valids, the rd fields and the priority bit; ready SHALL never be high while the matching valid is low.
REQ-018 SHALL keep one priority bit prio: 0 favours ALU, 1 favours MEM.
REQ-019 When en=1 and only one valid is high, SHALL grant that requester.
REQ-020 When en=1, both valid, alu_rd != mem_rd or both rd = 0, SHALL grant ALU if prio=0, else MEM.
REQ-021 When en=1, both valid, alu_rd = mem_rd != 0, SHALL grant MEM regardless of prio; MEM is always the older instruction.
REQ-022 On every grant SHALL update prio: ALU grant -> prio=1; MEM grant -> prio=0; no grant -> prio holds.
REQ-023 When en=0, SHALL drive both readies 0 and leave prio unchanged.
REQ-024 On a transfer with rd != 0, SHALL register wr_en=1, wr_addr=rd, wr_data=data, so the write appears in the cycle after acceptance; latency is exactly 1 cycle.
REQ-025 On a transfer with rd = 0, SHALL still accept it (ready=1) and update prio, but register wr_en=0; x0 is never written.
REQ-026 With no transfer, SHALL register wr_en=0, and wr_addr and wr_data SHALL hold their previous values.
REQ-027 Requesters SHALL hold valid, rd and data stable until ready; the arbiter has no storage beyond the output register and prio.
REQ-028 Back-to-back grants SHALL sustain one write per cycle with no bubble.

Reset
REQ-029 While rst_n=0, SHALL force wr_en=0, wr_addr=0, wr_data=0 and prio=0, independent of clk.
REQ-030 SHALL drive alu_ready and mem_ready to 0 while rst_n=0.
REQ-031 A request pending when reset asserts SHALL be discarded, with no write after rst_n deasserts.
REQ-032 After rst_n rises, the first contested grant SHALL go to ALU.

Verification
REQ-033 Reset: rst_n=0 with both valids high -> readies 0; wr_en=0, wr_addr=0, wr_data=0 immediately, with no clock edge needed.
REQ-034 Single: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
REQ-035 Round-robin: after reset, ALU rd=3 and MEM rd=7 held valid and re-presented for 4 cycles -> grants ALU, MEM, ALU, MEM; wr_addr sequence 3, 7, 3, 7 with wr_en=1 throughout.
REQ-036 Same-rd: prio=0, alu_rd=mem_rd=9 -> mem_ready=1, alu_ready=0; next cycle ALU granted; writes go to 9 from MEM data, then 9 from ALU data.
REQ-037 x0 and enable: alu_rd=0 -> alu_ready=1 with wr_en=0 next cycle; en=0 with both valid -> both readies 0 and prio unchanged.
REQ-038 Mid-operation reset: assert rst_n=0 between clock edges on the cycle after a grant -> wr_en drops to 0 immediately; no write to the granted rd after release.
